// File: rtl/qspi_psram_target.sv
// qspi_psram_target
// -----------------
// QSPI/QPI PSRAM-style target with an internal byte store.
//
// A transaction starts on the first rising edge that samples cs_n low. The
// command byte arrives as 8 serial bits on io_in[0] (SPI mode) or as two
// nibbles (QPI mode). The commands are:
//   0x38  write : 6 address nibbles, then data nibble pairs (high first)
//   0xEB  read  : 6 address nibbles, WAIT_CYCLES of latency, then streamed
//                 data nibbles (high first) until cs_n rises
//   0x35  enter QPI mode
// Any other command is ignored until cs_n rises.
//
// Optional feature, enabled by defining the macro QSPI_TARGET_QPI_EXIT_EN:
//   command 0xF5 received in QPI mode clears qpi_mode. When the macro is
//   not defined, 0xF5 is an unknown command and only reset_n clears
//   qpi_mode.
//
// Parameters:
//   MEM_BYTES   : size of the byte store, a power of two (>= 2)
//   WAIT_CYCLES : clocks from the last address nibble to the first read
//                 nibble (2..31)
//
// Ports:
//   clk      : clock; all pin sampling and driving on its rising edge
//   reset_n  : asynchronous active-low reset
//   cs_n     : chip select, active low
//   io_in    : QSPI data lines as sampled
//   io_out   : QSPI data lines as driven (0 whenever io_oe is 0)
//   io_oe    : per-line output enable (4'hF only while streaming read data)
//   qpi_mode : 1 when commands are received as nibbles
//   active   : 1 while a decoded transaction is in progress
module qspi_psram_target #(
  parameter int MEM_BYTES   = 256,
  parameter int WAIT_CYCLES = 12
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cs_n,
  input  logic [3:0] io_in,
  output logic [3:0] io_out,
  output logic [3:0] io_oe,
  output logic       qpi_mode,
  output logic       active
);

  localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_WAIT,
    ST_RDATA,
    ST_IGNORE
  } state_t;

  state_t          state_reg, state_next;
  logic [7:0]      cmd_reg, cmd_next;
  logic [4:0]      cnt_reg, cnt_next;
  logic [AW-1:0]   addr_reg, addr_next;
  logic [3:0]      hold_reg, hold_next;
  logic            phase_reg, phase_next;
  logic [3:0]      io_out_reg, io_out_next;
  logic [3:0]      io_oe_reg, io_oe_next;
  logic            qpi_reg, qpi_next;

  logic [7:0]      cmd_shift;
  logic            cmd_last;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [7:0]      wr_data;

  // Byte store; contents are deliberately left untouched by reset.
  logic [7:0]      mem [MEM_BYTES];
  logic [7:0]      rd_byte_reg;

  // ---------------------------------------------------------------------
  // Storage: synchronous write, registered read.
  // The read port is addressed with addr_next, so rd_byte_reg always holds
  // mem[addr_reg] during the following cycle. A write only ever targets
  // addr_reg while addr_next has already moved on to addr_reg+1, so the
  // registered read never races a write to the same byte.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_byte_reg <= mem[addr_next];
  end

  // ---------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= ST_IDLE;
      cmd_reg    <= 8'h00;
      cnt_reg    <= 5'd0;
      addr_reg   <= '0;
      hold_reg   <= 4'h0;
      phase_reg  <= 1'b0;
      io_out_reg <= 4'h0;
      io_oe_reg  <= 4'h0;
      qpi_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cmd_reg    <= cmd_next;
      cnt_reg    <= cnt_next;
      addr_reg   <= addr_next;
      hold_reg   <= hold_next;
      phase_reg  <= phase_next;
      io_out_reg <= io_out_next;
      io_oe_reg  <= io_oe_next;
      qpi_reg    <= qpi_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    cmd_next    = cmd_reg;
    cnt_next    = cnt_reg;
    addr_next   = addr_reg;
    hold_next   = hold_reg;
    phase_next  = phase_reg;
    qpi_next    = qpi_reg;
    io_oe_next  = 4'h0;
    io_out_next = 4'h0;
    wr_en       = 1'b0;
    wr_addr     = addr_reg;
    wr_data     = {hold_reg, io_in};

    // Command shift register takes a bit or a nibble depending on mode.
    cmd_shift = qpi_reg ? {cmd_reg[3:0], io_in} : {cmd_reg[6:0], io_in[0]};
    cmd_last  = qpi_reg ? (cnt_reg == 5'd1) : (cnt_reg == 5'd7);

    if (cs_n) begin
      // Deselect aborts anything in flight; a half byte or partial
      // address is simply dropped.
      state_next = ST_IDLE;
      cnt_next   = 5'd0;
      phase_next = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // This edge already carries the first command bit/nibble.
          state_next = ST_CMD;
          cmd_next   = qpi_reg ? {4'h0, io_in} : {7'h00, io_in[0]};
          cnt_next   = 5'd1;
        end

        ST_CMD: begin
          cmd_next = cmd_shift;
          cnt_next = cnt_reg + 5'd1;
          if (cmd_last) begin
            cnt_next = 5'd0;
            case (cmd_shift)
              8'h38, 8'hEB: state_next = ST_ADDR;
              8'h35: begin
                qpi_next   = 1'b1;
                state_next = ST_IGNORE;
              end
`ifdef QSPI_TARGET_QPI_EXIT_EN
              8'hF5: begin
                if (qpi_reg) begin
                  qpi_next = 1'b0;
                end
                state_next = ST_IGNORE;
              end
`endif
              default: state_next = ST_IGNORE;
            endcase
          end
        end

        ST_ADDR: begin
          // The address register doubles as the shift register; only the
          // low AW bits of the 24-bit address survive, which is exactly
          // the address modulo MEM_BYTES.
          addr_next = AW'({addr_reg, io_in});
          cnt_next  = cnt_reg + 5'd1;
          if (cnt_reg == 5'd5) begin
            cnt_next   = 5'd0;
            phase_next = 1'b0;
            state_next = (cmd_reg == 8'hEB) ? ST_WAIT : ST_WDATA;
          end
        end

        ST_WDATA: begin
          if (!phase_reg) begin
            hold_next  = io_in;
            phase_next = 1'b1;
          end else begin
            wr_en      = 1'b1;
            addr_next  = addr_reg + AW'(1);
            phase_next = 1'b0;
          end
        end

        ST_WAIT: begin
          // Entered on edge E (last address nibble); the edge with
          // cnt_reg == WAIT_CYCLES-1 is E+WAIT_CYCLES and puts out the
          // first data nibble.
          cnt_next = cnt_reg + 5'd1;
          if (cnt_reg == 5'(WAIT_CYCLES - 1)) begin
            cnt_next    = 5'd0;
            state_next  = ST_RDATA;
            io_oe_next  = 4'hF;
            io_out_next = rd_byte_reg[7:4];
            phase_next  = 1'b1;
          end
        end

        ST_RDATA: begin
          io_oe_next = 4'hF;
          if (phase_reg) begin
            io_out_next = rd_byte_reg[3:0];
            addr_next   = addr_reg + AW'(1);
            phase_next  = 1'b0;
          end else begin
            io_out_next = rd_byte_reg[7:4];
            phase_next  = 1'b1;
          end
        end

        ST_IGNORE: begin
          state_next = ST_IGNORE;
        end

        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign io_out   = io_out_reg;
  assign io_oe    = io_oe_reg;
  assign qpi_mode = qpi_reg;
  assign active   = (state_reg != ST_IDLE) && (state_reg != ST_IGNORE);

endmodule

// File: tb/tb_qspi_psram_target.sv
// Testbench for qspi_psram_target: random transactions checked against a
// byte-array model of the store plus a model of the qpi_mode flag.
module tb_qspi_psram_target;

  localparam int MEM = 256;
  localparam int W   = 12;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cs_n;
  logic [3:0] io_in;
  logic [3:0] io_out;
  logic [3:0] io_oe;
  logic       qpi_mode;
  logic       active;

  int total = 0;
  int bad   = 0;

  byte unsigned mem_m [MEM];
  byte unsigned wbuf  [MEM];
  bit           qpi_m;

  qspi_psram_target #(.MEM_BYTES(MEM), .WAIT_CYCLES(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cs_n     (cs_n),
    .io_in    (io_in),
    .io_out   (io_out),
    .io_oe    (io_oe),
    .qpi_mode (qpi_mode),
    .active   (active)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change on the falling edge; the DUT samples on the rising edge.
  task automatic put(input logic cs, input logic [3:0] io);
    @(negedge clk);
    cs_n  = cs;
    io_in = io;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    if (qpi_m) begin
      put(1'b0, c[7:4]);
      put(1'b0, c[3:0]);
    end else begin
      for (int i = 7; i >= 0; i--) put(1'b0, {3'($urandom), c[i]});
    end
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) put(1'b0, a[4*i +: 4]);
  endtask

  task automatic write_txn(input logic [23:0] a, input int n);
    send_cmd(8'h38);
    send_addr(a);
    for (int i = 0; i < n; i++) begin
      put(1'b0, wbuf[i][7:4]);
      put(1'b0, wbuf[i][3:0]);
      mem_m[(int'(a[7:0]) + i) % MEM] = wbuf[i];
    end
    @(negedge clk);
    total++;
    if (active !== 1'b1 || io_oe !== 4'h0) begin
      bad++;
      $display("FAIL write_busy: active=%b oe=%h want active=1 oe=0", active, io_oe);
    end
    cs_n  = 1'b1;
    io_in = 4'($urandom);
    $display("write addr=%06h bytes=%0d", a, n);
  endtask

  task automatic read_txn(input logic [23:0] a, input int n);
    bit quiet_ok;
    logic [3:0] exp_nib;
    byte unsigned b;
    send_cmd(8'hEB);
    send_addr(a);
    quiet_ok = 1'b1;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      if (io_oe !== 4'h0 || io_out !== 4'h0 || active !== 1'b1) quiet_ok = 1'b0;
      io_in = 4'($urandom);
    end
    total++;
    if (!quiet_ok) begin
      bad++;
      $display("FAIL read_wait: oe/out not quiet during latency at addr %06h (oe=%h) want oe=0 out=0 active=1",
               a, io_oe);
    end
    for (int j = 0; j < 2 * n; j++) begin
      @(negedge clk);
      b = mem_m[(int'(a[7:0]) + j / 2) % MEM];
      exp_nib = (j % 2 == 0) ? b[7:4] : b[3:0];
      total++;
      if (io_oe !== 4'hF || io_out !== exp_nib) begin
        bad++;
        $display("FAIL read_nibble: addr=%06h nib=%0d oe=%h out=%h want oe=F out=%h",
                 a, j, io_oe, io_out, exp_nib);
      end
      io_in = 4'($urandom);
    end
    cs_n = 1'b1;
    @(negedge clk);
    total++;
    if (io_oe !== 4'h0 || io_out !== 4'h0 || active !== 1'b0) begin
      bad++;
      $display("FAIL read_release: oe=%h out=%h active=%b want 0 0 0", io_oe, io_out, active);
    end
    $display("read  addr=%06h bytes=%0d", a, n);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    cs_n    = 1'b1;
    io_in   = 4'h0;
    repeat (3) @(negedge clk);
    total++;
    if (io_oe !== 4'h0 || io_out !== 4'h0 || qpi_mode !== 1'b0 || active !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: oe=%h out=%h qpi=%b active=%b want 0 0 0 0",
               io_oe, io_out, qpi_mode, active);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    qpi_m = 1'b0;
  endtask

  task automatic test_qpi_enter;
    logic [7:0] c;
    c = 8'h35;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      if (i == 0) begin
        total++;
        if (qpi_mode !== 1'b0 || active !== 1'b1 || io_oe !== 4'h0) begin
          bad++;
          $display("FAIL qpi_mid_cmd: qpi=%b active=%b oe=%h want 0 1 0", qpi_mode, active, io_oe);
        end
      end
      cs_n  = 1'b0;
      io_in = {3'($urandom), c[i]};
    end
    @(negedge clk);
    total++;
    if (qpi_mode !== 1'b1 || active !== 1'b0 || io_oe !== 4'h0) begin
      bad++;
      $display("FAIL qpi_set: qpi=%b active=%b oe=%h want 1 0 0", qpi_mode, active, io_oe);
    end
    cs_n = 1'b1;
    @(negedge clk);
    total++;
    if (qpi_mode !== 1'b1 || io_oe !== 4'h0) begin
      bad++;
      $display("FAIL qpi_after_cs: qpi=%b oe=%h want 1 0", qpi_mode, io_oe);
    end
    qpi_m = 1'b1;
    $display("cmd 35 (spi) qpi=%b", qpi_mode);
  endtask

  task automatic test_fill;
    for (int i = 0; i < MEM; i++) wbuf[i] = 8'($urandom);
    write_txn(24'h000000, MEM);
    read_txn(24'h000000, 4);
  endtask

  task automatic test_basic;
    wbuf[0] = 8'hA5;
    wbuf[1] = 8'hC3;
    write_txn(24'h000010, 2);
    read_txn(24'h000010, 2);
  endtask

  task automatic test_wrap;
    wbuf[0] = 8'h11;
    wbuf[1] = 8'h22;
    write_txn(24'h0000FF, 2);
    read_txn(24'h0000FF, 1);
    read_txn(24'h000000, 1);
    read_txn(24'h0000FF, 3);
  endtask

  task automatic test_partial;
    logic [23:0] a;
    logic [7:0]  nb;
    a  = 24'($urandom);
    nb = 8'($urandom);
    send_cmd(8'h38);
    send_addr(a);
    put(1'b0, nb[7:4]);
    put(1'b0, nb[3:0]);
    put(1'b0, ~mem_m[(int'(a[7:0]) + 1) % MEM][7:4]);
    put(1'b1, 4'($urandom));
    mem_m[a[7:0]] = nb;
    $display("write addr=%06h nibbles=3 (aborted)", a);
    read_txn(a, 2);
    // Abort in the middle of an address: nothing may be written.
    send_cmd(8'h38);
    put(1'b0, 4'($urandom));
    put(1'b0, 4'($urandom));
    put(1'b0, 4'($urandom));
    put(1'b1, 4'($urandom));
    $display("write partial address (aborted)");
  endtask

  task automatic test_random;
    logic [23:0] a;
    int n;
    for (int it = 0; it < 12; it++) begin
      a = 24'($urandom);
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      write_txn(a, n);
      read_txn(24'($urandom), $urandom_range(1, 4));
      read_txn(a, n + 1);
    end
  endtask

  task automatic test_unknown;
    logic [7:0] c;
    for (int it = 0; it < 3; it++) begin
      do c = 8'($urandom);
      while (c == 8'h38 || c == 8'hEB || c == 8'h35 || c == 8'hF5);
      send_cmd(c);
      @(negedge clk);
      total++;
      if (active !== 1'b0 || io_oe !== 4'h0 || qpi_mode !== qpi_m) begin
        bad++;
        $display("FAIL unknown_cmd %02h: active=%b oe=%h qpi=%b want 0 0 %b",
                 c, active, io_oe, qpi_mode, qpi_m);
      end
      cs_n  = 1'b0;
      io_in = 4'($urandom);
      repeat (16) put(1'b0, 4'($urandom));
      put(1'b1, 4'h0);
      $display("cmd %02h ignored", c);
    end
    read_txn(24'h000010, 2);
  endtask

  task automatic test_qpi_exit;
    bit exp_qpi;
`ifdef QSPI_TARGET_QPI_EXIT_EN
    exp_qpi = 1'b0;
`else
    exp_qpi = 1'b1;
`endif
    send_cmd(8'hF5);
    @(negedge clk);
    total++;
    if (qpi_mode !== exp_qpi || active !== 1'b0 || io_oe !== 4'h0) begin
      bad++;
      $display("FAIL qpi_exit: qpi=%b active=%b oe=%h want %b 0 0", qpi_mode, active, io_oe, exp_qpi);
    end
    cs_n = 1'b1;
    @(negedge clk);
    qpi_m = exp_qpi;
    $display("cmd F5 qpi=%b", qpi_mode);
    if (!qpi_m) test_qpi_enter();
  endtask

  task automatic test_reset_mid_read;
    send_cmd(8'hEB);
    send_addr(24'($urandom));
    repeat (W + 3) @(negedge clk);
    total++;
    if (io_oe !== 4'hF) begin
      bad++;
      $display("FAIL rst_read_pre: oe=%h want F", io_oe);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (io_oe !== 4'h0 || io_out !== 4'h0 || qpi_mode !== 1'b0 || active !== 1'b0) begin
      bad++;
      $display("FAIL rst_read_async: oe=%h out=%h qpi=%b active=%b want 0 0 0 0",
               io_oe, io_out, qpi_mode, active);
    end
    @(negedge clk);
    cs_n = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    qpi_m = 1'b0;
    $display("read aborted by reset");
  endtask

  task automatic test_spi_txn;
    logic [23:0] a;
    a = 24'($urandom);
    wbuf[0] = 8'($urandom);
    wbuf[1] = 8'($urandom);
    write_txn(a, 2);
    read_txn(a, 2);
    read_txn(24'h000010, 1);
  endtask

  initial begin
    reset_n = 1'b0;
    cs_n    = 1'b1;
    io_in   = 4'h0;
    qpi_m   = 1'b0;
    test_reset();
    test_qpi_enter();
    test_fill();
    test_basic();
    test_wrap();
    test_partial();
    test_random();
    test_unknown();
    test_qpi_exit();
    test_reset_mid_read();
    test_spi_txn();
    test_qpi_enter();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qspi_psram_target.md
QSPI_PSRAM_TARGET -- requirements
Module: qspi_psram_target

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 256, power of two; size of internal byte storage.
REQ-002 SHALL have parameter WAIT_CYCLES, default 12, range 2..31; clocks from the last address nibble to the first read-data nibble.
REQ-003 SHALL have port clk, input, 1; the only clock; all pin sampling and driving on its rising edge.
REQ-004 SHALL have port reset_n, input, 1; asynchronous, active-low reset.
REQ-005 SHALL have port cs_n, input, 1; chip select, active low.
REQ-006 SHALL have port io_in, input, 4; QSPI data lines as sampled.
REQ-007 SHALL have port io_out, output, 4; QSPI data lines as driven.
REQ-008 SHALL have port io_oe, output, 4; per-line output enable.
REQ-009 SHALL have port qpi_mode, output, 1; 1 when commands are received as nibbles.
REQ-010 SHALL have port active, output, 1; 1 while a transaction is decoded and not finished.

Function
- REQ-011 Pin handling SHALL be one bit or nibble per clk, with cs_n and io_in sampled on every rising edge.
- REQ-012 States SHALL be IDLE, CMD, ADDR, WDATA, WAIT, RDATA and IGNORE.
- REQ-013 IDLE SHALL go to CMD on the first edge with cs_n low, and that edge's io_in SHALL be the first command bit or nibble.
- REQ-014 CMD in SPI mode (qpi_mode=0) SHALL receive 8 bits, MSB first, on io_in[0].
- REQ-015 CMD in QPI mode SHALL receive 2 nibbles, high nibble first.
- REQ-016 Command decode SHALL be: 0x38 = write, 0xEB = read, 0x35 = set qpi_mode; any other value SHALL go to IGNORE.
- REQ-017 Command 0x35 SHALL set qpi_mode on the edge after its last bit and then go to IGNORE.
- REQ-018 ADDR SHALL receive 6 nibbles, high first, forming a 24-bit address used modulo MEM_BYTES.
- REQ-019 Write data in WDATA SHALL be nibble pairs, high nibble first; each byte SHALL be committed on its second nibble, then the address incremented with wrap at MEM_BYTES.
- REQ-020 WAIT SHALL keep io_oe=0 for WAIT_CYCLES-1 clocks and SHALL ignore io_in.
- REQ-021 RDATA SHALL set io_oe=4'hF and present one nibble per clk, high nibble first, with the address incremented with wrap after each low nibble, and SHALL stream until cs_n rises.
- REQ-022 Read latency: with the last address nibble sampled at edge E, io_out SHALL carry the first data nibble with io_oe=4'hF from edge E+WAIT_CYCLES.
- REQ-023 io_oe SHALL be 0 in every state except RDATA, and io_out SHALL be 0 whenever io_oe=0.
- REQ-024 Any edge sampling cs_n=1 SHALL go to IDLE and drop io_oe on that same edge; a half-received byte or partial address SHALL be discarded without any memory write.
- REQ-025 Read-after-write to the same byte in consecutive transactions SHALL return the new data.
- REQ-026 active SHALL be 1 in CMD, ADDR, WDATA, WAIT and RDATA, and 0 in IDLE and IGNORE.

Reset
- REQ-027 Asserting reset_n low SHALL immediately force state=IDLE, io_oe=0, io_out=0, qpi_mode=0 and active=0.
- REQ-028 Reset SHALL NOT initialise storage contents, and a reset mid-read SHALL release io_oe asynchronously.

Configuration
- REQ-029 With QSPI_TARGET_QPI_EXIT_EN defined, command 0xF5 received in QPI mode SHALL clear qpi_mode after its last nibble and then go to IGNORE.
- REQ-030 Without QSPI_TARGET_QPI_EXIT_EN, 0xF5 SHALL be treated as an unknown command, and only reset_n SHALL clear qpi_mode.

Verification
- REQ-031 Reset, then SPI command 0x35 on io_in[0], then cs_n high, SHALL give qpi_mode=1 and io_oe=0 throughout.
- REQ-032 In QPI mode, write cmd 3,8, address 0x000010, data 4'hA,5,C,3, then read cmd E,B with the same address, SHALL return nibbles A,5,C,3 exactly WAIT_CYCLES edges after the last address nibble.
- REQ-033 With MEM_BYTES=256, writing bytes 0x11,0x22 at address 0x0000FF SHALL store 0x11 at 0xFF and 0x22 at 0x00.
- REQ-034 Raising cs_n after 3 write data nibbles SHALL change only the first byte, and a read SHALL show the second byte unchanged.
- REQ-035 Asserting reset_n low during RDATA SHALL drop io_oe to 0 before the next clk edge and clear qpi_mode.
- REQ-036 With QSPI_TARGET_QPI_EXIT_EN defined, cmd F,5 in QPI mode SHALL clear qpi_mode; without it, qpi_mode SHALL stay 1 and the transaction SHALL go to IGNORE.
